// File: rtl/keypad_matrix_scan.sv
// Row-scanning keypad matrix controller with tick-based press/release debounce.
// Optional autorepeat of key_valid while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scan #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY   = 64,
  parameter int unsigned REPEAT_RATE    = 16,
`endif
  localparam int unsigned CODE_W        = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [ROW_W-1:0]  row_q;
  logic [7:0]        cnt_q;
  logic [CODE_W-1:0] cand_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0]       rep_cnt_q;
  logic              rep_first_q;
  logic [15:0]       rep_inc;
  logic              rep_fire;
`endif

  logic              tick;
  logic              press;
  logic [COL_W-1:0]  det_col;
  logic [CODE_W-1:0] det_code;
  logic [ROW_W-1:0]  row_next;
  logic [7:0]        cnt_inc;
  logic              cnt_done;
  logic              cand_match;
  logic              held_match;

  assign tick       = (div_q == DIV_W'(SCAN_DIV - 1));
  assign row_next   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
  assign cnt_inc    = cnt_q + 8'd1;
  assign cnt_done   = (cnt_inc == 8'(DEBOUNCE_SCANS));
  assign det_code   = CODE_W'(32'(row_q) * COLS + 32'(det_col));
  assign cand_match = press && (det_code == cand_q);
  assign held_match = press && (det_code == key_code);

`ifdef KEYPAD_AUTOREPEAT_EN
  assign rep_inc  = rep_cnt_q + 16'd1;
  assign rep_fire = rep_first_q ? (rep_inc == 16'(REPEAT_DELAY)) : (rep_inc == 16'(REPEAT_RATE));
`endif

  // Lowest-index active column wins when several keys share the driven row.
  always_comb begin
    press   = 1'b0;
    det_col = '0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (!col_n[c]) begin
        press   = 1'b1;
        det_col = COL_W'(c);
      end
    end
  end

  always_comb begin
    row_n        = '1;
    row_n[row_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      div_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      div_q       <= tick ? '0 : div_q + DIV_W'(1);
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (press) begin
              cand_q  <= det_code;
              cnt_q   <= '0;
              state_q <= StDebounce;
            end else begin
              row_q <= row_next;
            end
          end
          StDebounce: begin
            if (!cand_match) begin
              state_q <= StScan;
            end else if (cnt_done) begin
              key_code  <= cand_q;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state_q   <= StHeld;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_q   <= '0;
              rep_first_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StHeld: begin
            if (!held_match) begin
              cnt_q   <= '0;
              state_q <= StRelease;
`ifdef KEYPAD_AUTOREPEAT_EN
            end else if (rep_fire) begin
              key_valid   <= 1'b1;
              rep_cnt_q   <= '0;
              rep_first_q <= 1'b0;
            end else begin
              rep_cnt_q <= rep_inc;
`endif
            end
          end
          StRelease: begin
            if (held_match) begin
              state_q <= StHeld;
            end else if (press) begin
              // Another key in the frozen row breaks the run of clean no-press ticks.
              cnt_q <= '0;
            end else if (cnt_done) begin
              key_release <= 1'b1;
              key_held    <= 1'b0;
              cnt_q       <= '0;
              state_q     <= StScan;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Self-checking bench for keypad_matrix_scan: a physical key-matrix model drives col_n, and
// expected pulses come from tick-arithmetic predictions of scan position and debounce windows.
module tb_keypad_matrix_scan;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int n_valid;
  int n_release;
  int s;
  logic [3:0] last_code;
  bit rep_en;

  always #5 clk = ~clk;

  keypad_matrix_scan #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY  (8),
    .REPEAT_RATE   (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .key_release(key_release)
  );

  // Pressed switch at (r,c) shorts row r to column c.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_n[r] && keys[r*COLS+c]) col_n[c] = 1'b0;
  end

  typedef struct {
    int         row;
    logic [3:0] cmask;
    int         press;
    bit         exp_valid;
    logic [3:0] exp_code;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    if (key_valid) n_valid++;
    if (key_release) n_release++;
    check("no_overlap", int'(key_valid && key_release), 0);
  endtask

  task automatic step_tick();
    n_valid   = 0;
    n_release = 0;
    repeat (SCAN_DIV) step_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_n"}, int'(row_n), 4'b1110);
    check({tag, "_code"}, int'(key_code), 0);
    check({tag, "_valid"}, int'(key_valid), 0);
    check({tag, "_held"}, int'(key_held), 0);
    check({tag, "_release"}, int'(key_release), 0);
  endtask

  // Press cmask on row for 'press' ticks then idle 'gap' ticks; predictions are pure tick arithmetic.
  task automatic run_trial(input int row, input logic [3:0] cmask, input int press, input int gap,
                           output int got_valid, output logic [3:0] got_code);
    int lc, w, acc, rel;
    bit detected, accepted;
    logic [3:0] code, exp_row_n;
    lc = 0;
    for (int c = 3; c >= 0; c--) if (cmask[c]) lc = c;
    code      = 4'(row * COLS + lc);
    exp_row_n = ~(4'(1) << s);
    check("trial_row_n", int'(row_n), int'(exp_row_n));
    w        = (row - s + ROWS) % ROWS;
    detected = (w < press);
    acc      = w + DEB;
    accepted = detected && (acc < press);
    rel      = press + DEB;
    got_valid = 0;
    got_code  = '0;
    keys = 16'(cmask) << (row * COLS);
    for (int j = 0; j < press + gap; j++) begin
      if (j == press) keys = '0;
      step_tick();
      check("trial_valid", n_valid, (accepted && j == acc) ? 1 : 0);
      check("trial_release", n_release, (accepted && j == rel) ? 1 : 0);
      check("trial_held", int'(key_held), (accepted && j >= acc && j < rel) ? 1 : 0);
      if (n_valid > 0) begin
        got_code = key_code;
        check("trial_code", int'(key_code), int'(code));
      end
      got_valid += n_valid;
    end
    if (!detected) s = (s + press + gap) % ROWS;
    else if (accepted) begin
      s = (row + gap - DEB - 1) % ROWS;
      last_code = code;
    end else s = (row + gap - 1) % ROWS;
    check("trial_code_retained", int'(key_code), int'(last_code));
  endtask

  task automatic wait_accept(input string tag, output bit found);
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step_tick();
      if (n_valid > 0) found = 1;
    end
    check({tag, "_accept_seen"}, int'(found), 1);
  endtask

  initial begin
    vec_t tbl[6];
    int gv, tot, row;
    logic [3:0] gc, code;
    bit found;

`ifdef KEYPAD_AUTOREPEAT_EN
    rep_en = 1;
`else
    rep_en = 0;
`endif

    tbl[0] = '{2, 4'b0010, 10, 1'b1, 4'd9};
    tbl[1] = '{2, 4'b0010, 2, 1'b0, 4'd0};
    tbl[2] = '{1, 4'b0011, 10, 1'b1, 4'd4};
    tbl[3] = '{3, 4'b1000, 10, 1'b1, 4'd15};
    tbl[4] = '{0, 4'b0001, 1, 1'b0, 4'd0};
    tbl[5] = '{0, 4'b0100, 9, 1'b1, 4'd2};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    s = 0;
    last_code = '0;

    for (int i = 0; i < 6; i++) begin
      run_trial(tbl[i].row, tbl[i].cmask, tbl[i].press, 6, gv, gc);
      check("tbl_valid_count", gv, int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check("tbl_code", int'(gc), int'(tbl[i].exp_code));
    end

    // Release with a single-tick bounce back onto the held key.
    keys = 16'(4'b0010) << 8;
    wait_accept("bounce", found);
    check("bounce_code", int'(key_code), 9);
    keys = '0;
    step_tick();
    check("bounce_rel0", n_release, 0);
    check("bounce_held0", int'(key_held), 1);
    keys = 16'(4'b0010) << 8;
    step_tick();
    check("bounce_back_valid", n_valid, 0);
    check("bounce_back_rel", n_release, 0);
    check("bounce_back_held", int'(key_held), 1);
    keys = '0;
    for (int k = 0; k < 5; k++) begin
      step_tick();
      check("bounce_release", n_release, (k == 4) ? 1 : 0);
      check("bounce_held", int'(key_held), (k < 4) ? 1 : 0);
    end
    step_tick();
    check("bounce_release_once", n_release, 0);
    check("bounce_code_kept", int'(key_code), 9);
    last_code = 4'd9;
    s = 3;

    // Long hold: single key_valid, or autorepeat at +8 then every +4 ticks.
    row  = s;
    code = 4'(row * COLS);
    keys = 16'(1) << (row * COLS);
    tot  = 0;
    for (int j = 0; j < 25; j++) begin
      step_tick();
      check("hold_valid", n_valid,
            (j == 4 || (rep_en && (j == 12 || j == 16 || j == 20 || j == 24))) ? 1 : 0);
      check("hold_held", int'(key_held), (j >= 4) ? 1 : 0);
      tot += n_valid;
    end
    check("hold_total_valid", tot, rep_en ? 5 : 1);
    check("hold_code", int'(key_code), int'(code));
    keys = '0;
    for (int k = 0; k < 5; k++) begin
      step_tick();
      check("hold_release", n_release, (k == 4) ? 1 : 0);
    end
    last_code = code;
    s = row;

    // Reset landing exactly on the edge that would accept the press.
    keys = 16'(4'b0100) << (s * COLS);
    step_tick();
    for (int k = 0; k < 3; k++) begin
      step_tick();
      check("rstdeb_pre_valid", n_valid, 0);
    end
    n_valid   = 0;
    n_release = 0;
    repeat (SCAN_DIV - 1) step_cycle();
    rst  = 1'b1;
    keys = '0;
    step_cycle();
    check_reset_outputs("rstdeb");
    rst = 1'b0;
    tot = n_valid + n_release;
    for (int k = 0; k < 6; k++) begin
      step_tick();
      tot += n_valid + n_release;
    end
    check("rstdeb_no_pulses", tot, 0);
    s = 2;
    last_code = '0;

    // Reset while a key is held must not produce key_release.
    keys = 16'(4'b1000) << (s * COLS);
    wait_accept("rsthold", found);
    check("rsthold_code", int'(key_code), s * COLS + 3);
    step_tick();
    step_tick();
    n_release = 0;
    repeat (2) step_cycle();
    rst  = 1'b1;
    keys = '0;
    step_cycle();
    check_reset_outputs("rsthold");
    rst = 1'b0;
    tot = n_release;
    for (int k = 0; k < 6; k++) begin
      step_tick();
      tot += n_valid + n_release;
    end
    check("rsthold_no_pulses", tot, 0);
    s = 2;
    last_code = '0;

    for (int t = 0; t < 40; t++) begin
      run_trial(int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                int'($urandom_range(1, 10)), int'($urandom_range(5, 8)), gv, gc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
